// File: rtl/result_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD result converter: FSM encoding,
// seven-segment patterns (active-low {g,f,e,d,c,b,a}) and default width.
package result_bcd_converter_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int SCRATCH_W     = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/result_bcd_converter_bcd_to_7seg.sv
// Purely combinational BCD digit to active-low seven-segment decode;
// codes 10..15 render as a dark digit.
module bcd_to_7seg
   import result_bcd_converter_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: one operand bit per cycle, then the
// digits and their segment patterns are registered together in LOAD.
module result_bcd_converter
   import result_bcd_converter_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bcd_hund,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic [6:0]       seg_hund,
   output logic [6:0]       seg_tens,
   output logic [6:0]       seg_ones,
   output logic [1:0]       dbg_state_o
);

   // Leading digits power up dark when blanking is on, otherwise show 0.
   localparam logic [6:0] SEG_LEAD_RST = BLANK_LEADING ? SEG_BLANK : SEG_0;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       opnd_q, opnd_d;
   logic [SCRATCH_W-1:0]   scr_q, scr_d, adj;
   logic [3:0]             cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   load;
   logic [SCRATCH_W-1:0]   bcd_q;
   logic [6:0]             seg_h_q, seg_t_q, seg_o_q;
   logic [6:0]             raw_h, raw_t, raw_o;
   logic [6:0]             seg_h_d, seg_t_d;

   always_comb begin
      adj = scr_q;
      for (int i = 0; i < 3; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               opnd_d  = bin_in;
               scr_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {scr_d, opnd_d} = {adj, opnd_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(WIDTH - 1)) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            load    = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   bcd_to_7seg u_dec_hund (.digit_i(scr_q[11:8]), .seg_o(raw_h));
   bcd_to_7seg u_dec_tens (.digit_i(scr_q[7:4]),  .seg_o(raw_t));
   bcd_to_7seg u_dec_ones (.digit_i(scr_q[3:0]),  .seg_o(raw_o));

   // The tens digit is only dark when the hundreds digit is dark too.
   always_comb begin
      seg_h_d = raw_h;
      seg_t_d = raw_t;
      if (BLANK_LEADING && scr_q[11:8] == 4'd0) begin
         seg_h_d = SEG_BLANK;
         if (scr_q[7:4] == 4'd0) seg_t_d = SEG_BLANK;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         opnd_q  <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         seg_h_q <= SEG_LEAD_RST;
         seg_t_q <= SEG_LEAD_RST;
         seg_o_q <= SEG_0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (load) begin
            bcd_q   <= scr_q;
            seg_h_q <= seg_h_d;
            seg_t_q <= seg_t_d;
            seg_o_q <= raw_o;
         end
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign bcd_hund    = bcd_q[11:8];
   assign bcd_tens    = bcd_q[7:4];
   assign bcd_ones    = bcd_q[3:0];
   assign seg_hund    = seg_h_q;
   assign seg_tens    = seg_t_q;
   assign seg_ones    = seg_o_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: cycle-level reference model from the
// decimal meaning of the result, plus directed cases with literal digits.
module tb_result_bcd_converter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] bin_in = '0;
   logic       busy, done;
   logic [3:0] bcd_hund, bcd_tens, bcd_ones;
   logic [6:0] seg_hund, seg_tens, seg_ones;
   logic [1:0] dbg_state;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   result_bcd_converter #(.WIDTH(8), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done),
      .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
      .seg_hund(seg_hund), .seg_tens(seg_tens), .seg_ones(seg_ones),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [11:0] exp_q[$];
   int          m_phase  = 0;
   logic        m_done   = 1'b0;
   logic [11:0] m_digits = '0;

   function automatic logic [11:0] to_bcd(int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] seg_of(logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase  <= 0;
         m_done   <= 1'b0;
         m_digits <= '0;
         exp_q.delete();
      end else begin
         m_done <= 1'b0;
         if (m_phase == 0) begin
            if (start) begin
               exp_q.push_back(to_bcd(int'(bin_in)));
               m_phase <= 9;
            end
         end else begin
            m_phase <= m_phase - 1;
            if (m_phase == 1) begin
               m_done   <= 1'b1;
               m_digits <= exp_q.pop_front();
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy", 32'(busy), 32'(m_phase != 0));
         chk("model_done", 32'(done), 32'(m_done));
         chk("model_bcd", 32'({bcd_hund, bcd_tens, bcd_ones}), 32'(m_digits));
         chk("model_seg_hund", 32'(seg_hund),
             32'((m_digits[11:8] == 0) ? 7'h7f : seg_of(m_digits[11:8])));
         chk("model_seg_tens", 32'(seg_tens),
             32'((m_digits[11:4] == 0) ? 7'h7f : seg_of(m_digits[7:4])));
         chk("model_seg_ones", 32'(seg_ones), 32'(seg_of(m_digits[3:0])));
      end
   end

   // ---------------- drivers ----------------
   task automatic do_start(input logic [7:0] v, input bit now);
      if (!now) @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(negedge clk);
      start  = 1'b0;
      bin_in = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      while (!done && lat < 30) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic chk_out(input string name, input logic [11:0] digits,
                          input logic [6:0] sh, input logic [6:0] st, input logic [6:0] so);
      chk({name, "_bcd"}, 32'({bcd_hund, bcd_tens, bcd_ones}), 32'(digits));
      chk({name, "_seg_hund"}, 32'(seg_hund), 32'(sh));
      chk({name, "_seg_tens"}, 32'(seg_tens), 32'(st));
      chk({name, "_seg_ones"}, 32'(seg_ones), 32'(so));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat, bc, k;
      logic [7:0] v;

      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk_out("reset", 12'h000, 7'b1111111, 7'b1111111, 7'b1000000);
      rst    = 1'b1;
      chk_en = 1'b1;

      do_start(8'd0, 1'b0);
      wait_done(lat, bc);
      chk("zero_latency", 32'(lat), 32'd9);
      chk_out("zero", 12'h000, 7'b1111111, 7'b1111111, 7'b1000000);

      do_start(8'd255, 1'b0);
      wait_done(lat, bc);
      chk("max_busy_cycles", 32'(bc), 32'd9);
      chk_out("max", 12'h255, 7'b0100100, 7'b0010010, 7'b0010010);

      do_start(8'd100, 1'b0);
      wait_done(lat, bc);
      chk_out("hundred", 12'h100, 7'b1111001, 7'b1000000, 7'b1000000);

      do_start(8'd7, 1'b0);
      wait_done(lat, bc);
      chk_out("seven", 12'h007, 7'b1111111, 7'b1111111, 7'b1111000);

      // A second request while busy must be dropped.
      do_start(8'd42, 1'b0);
      repeat (2) @(negedge clk);
      do_start(8'd99, 1'b1);
      wait_done(lat, bc);
      chk("ignored_latency", 32'(lat), 32'd6);
      chk_out("ignored", 12'h042, 7'b1111111, 7'b0011001, 7'b0100100);
      @(negedge clk);
      chk("ignored_no_second_done", 32'(done), 32'd0);

      // Back-to-back: new request raised during the done cycle.
      do_start(8'd58, 1'b0);
      wait_done(lat, bc);
      chk_out("b2b_first", 12'h058, 7'b1111111, 7'b0010010, 7'b0000000);
      do_start(8'd199, 1'b1);
      wait_done(lat, bc);
      chk("b2b_latency", 32'(lat), 32'd9);
      chk_out("b2b_second", 12'h199, 7'b1111001, 7'b0010000, 7'b0010000);

      // Reset in the middle of a conversion.
      do_start(8'd200, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk_out("abort", 12'h000, 7'b1111111, 7'b1111111, 7'b1000000);
      k = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) k++;
      end
      chk("abort_no_done", 32'(k), 32'd0);
      rst = 1'b1;
      do_start(8'd13, 1'b0);
      wait_done(lat, bc);
      chk("after_reset_latency", 32'(lat), 32'd9);
      chk_out("after_reset", 12'h013, 7'b1111111, 7'b1111001, 7'b0110000);

      // Random values, random ignored requests, random gaps.
      for (int n = 0; n < 40; n++) begin
         v = 8'($urandom_range(0, 255));
         do_start(v, 1'b0);
         k = 0;
         if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 6);
            repeat (k) @(negedge clk);
            do_start(8'($urandom_range(0, 255)), 1'b1);
            k = k + 1;
         end
         wait_done(lat, bc);
         chk("rand_latency", 32'(lat + k), 32'd9);
         chk("rand_value", 32'({bcd_hund, bcd_tens, bcd_ones}), 32'(to_bcd(int'(v))));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
